// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
interface load_store_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store stage: memory handshake, byte lanes, load extension, timeout.
// Optional macro LSU_MISALIGN_TRAP_EN faults misaligned halfword/word accesses instead of masking the offset.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     is_store,
   input  logic [2:0]               funct3,
   input  logic [31:0]              addr,
   input  logic [31:0]              store_data,
   load_store_unit_if.master        mem,
   output logic                     busy,
   output logic                     done,
   output logic [31:0]              load_data,
   output logic                     fault
);

   localparam logic [7:0] TMO_CNT = 8'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t      state_q;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic [7:0]  cnt_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic [3:0]  mem_wstrb_q;
   logic        busy_q;
   logic        done_q;
   logic        fault_q;
   logic [31:0] load_data_q;

   logic        legal_d;
   logic        trap_d;
   logic [3:0]  wstrb_d;
   logic [31:0] wdata_d;
   logic [7:0]  byte_d;
   logic [15:0] half_d;
   logic [31:0] ld_ext_d;

   // Decode and lane generation work on the raw inputs so they can be registered on the accept edge.
   always_comb begin
      legal_d = 1'b0;
      wstrb_d = '0;
      wdata_d = '0;
      if (is_store) begin
         case (funct3)
            3'b000: begin
               legal_d = 1'b1;
               wstrb_d = 4'b0001 << addr[1:0];
               wdata_d = {4{store_data[7:0]}};
            end
            3'b001: begin
               legal_d = 1'b1;
               wstrb_d = 4'b0011 << {addr[1], 1'b0};
               wdata_d = {2{store_data[15:0]}};
            end
            3'b010: begin
               legal_d = 1'b1;
               wstrb_d = 4'b1111;
               wdata_d = store_data;
            end
            default: legal_d = 1'b0;
         endcase
      end else begin
         case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_d = 1'b1;
            default:                                legal_d = 1'b0;
         endcase
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic misalign_d;
   assign misalign_d = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
   assign trap_d     = !legal_d || misalign_d;
`else
   assign trap_d     = !legal_d;
`endif

   always_comb begin
      byte_d   = mem.mem_rdata[{off_q, 3'b000} +: 8];
      half_d   = mem.mem_rdata[{off_q[1], 4'b0000} +: 16];
      ld_ext_d = '0;
      case (funct3_q)
         3'b000:  ld_ext_d = {{24{byte_d[7]}}, byte_d};
         3'b001:  ld_ext_d = {{16{half_d[15]}}, half_d};
         3'b010:  ld_ext_d = mem.mem_rdata;
         3'b100:  ld_ext_d = {24'd0, byte_d};
         3'b101:  ld_ext_d = {16'd0, half_d};
         default: ld_ext_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         funct3_q    <= '0;
         off_q       <= '0;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
         load_data_q <= '0;
      end else begin
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  funct3_q <= funct3;
                  off_q    <= addr[1:0];
                  busy_q   <= 1'b1;
                  if (trap_d) begin
                     state_q <= RESP;
                     done_q  <= 1'b1;
                     fault_q <= 1'b1;
                  end else begin
                     state_q     <= ACCESS;
                     cnt_q       <= '0;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= is_store;
                     mem_addr_q  <= {addr[31:2], 2'b00};
                     mem_wdata_q <= wdata_d;
                     mem_wstrb_q <= wstrb_d;
                  end
               end
            end
            ACCESS: begin
               // A ready arriving on the final counted cycle still completes normally.
               if (mem.mem_ready) begin
                  state_q   <= RESP;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  done_q    <= 1'b1;
                  if (!mem_we_q) begin
                     load_data_q <= ld_ext_d;
                  end
               end else if (cnt_q + 8'd1 == TMO_CNT) begin
                  state_q   <= RESP;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  cnt_q     <= '0;
                  done_q    <= 1'b1;
                  fault_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q   <= IDLE;
               busy_q    <= 1'b0;
               mem_req_q <= 1'b0;
               mem_we_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;
   assign mem.mem_wstrb = mem_wstrb_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign fault         = fault_q;
   assign load_data     = load_data_q;

endmodule
